lc3_decode_stage: RTL



---
 rtl/lc3_decode_stage.sv | 65 ++++++
 1 files changed

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: registers the fetched LC3 instruction and npc and decodes the
// execute/writeback/memory control words for the execute stage.
module lc3_decode_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [5:0]        E_Control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control,
    output logic              illegal_op,
    output logic              decode_valid
);
    logic [3:0]        op;
    logic [DATA_W-1:0] ir_q, npc_q;
    logic [5:0]        e_d, e_q;
    logic [1:0]        w_d, w_q, alu_d, pcs1_d;
    logic              mem_d, mem_q, ill_d, ill_q, valid_q, off9, op2_d;
    assign op = dout[15:12];
    // Unsupported opcodes leave every control field at zero.
    always_comb begin
        ill_d  = op inside {4'b0100, 4'b1000, 4'b1101, 4'b1111};
        off9   = op inside {4'b0000, 4'b0010, 4'b1010, 4'b0011, 4'b1011, 4'b1110};
        alu_d  = op == 4'b0101 ? 2'b01 : op == 4'b1001 ? 2'b10 : 2'b00;
        pcs1_d = off9 ? 2'b01 : (op == 4'b0110 || op == 4'b0111) ? 2'b10 :
                 op == 4'b1100 ? 2'b11 : 2'b00;
        op2_d  = (op == 4'b0001 || op == 4'b0101) && !dout[5];
        e_d    = {alu_d, pcs1_d, off9, op2_d};
        w_d    = (op inside {4'b0010, 4'b0110, 4'b1010}) ? 2'b01 : op == 4'b1110 ? 2'b10 : 2'b00;
        mem_d  = op == 4'b1010 || op == 4'b1011;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q    <= '0;
            npc_q   <= '0;
            e_q     <= '0;
            w_q     <= '0;
            mem_q   <= 1'b0;
            ill_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= enable_decode;
            if (enable_decode) begin
                ir_q  <= dout;
                npc_q <= npc_in;
                e_q   <= e_d;
                w_q   <= w_d;
                mem_q <= mem_d;
                ill_q <= ill_d;
            end
        end
    end
    assign IR           = ir_q;
    assign npc_out      = npc_q;
    assign E_Control    = e_q;
    assign W_Control    = w_q;
    assign Mem_Control  = mem_q;
    assign illegal_op   = ill_q;
    assign decode_valid = valid_q;
endmodule
